// File: rtl/axi_pkg.sv
// Shared AXI-lite request/response bundles (32-bit address and data).
package axi_pkg;

  typedef struct packed {
    logic [31:0] awaddr;
    logic        awvalid;
    logic [31:0] wdata;
    logic        wvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        rready;
  } axi_lite_mosi;

  typedef struct packed {
    logic        awready;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
  } axi_lite_miso;

endpackage

// File: rtl/goertzel_pkg.sv
// Register map, bit positions, response codes and sequencer states for goertzel_ctrl.
package goertzel_pkg;

  localparam logic [31:0] REG_CTRL   = 32'h00;
  localparam logic [31:0] REG_STATUS = 32'h04;
  localparam logic [31:0] REG_LEN    = 32'h08;
  localparam logic [31:0] REG_COEFF  = 32'h0C;
  localparam logic [31:0] REG_RESULT = 32'h10;
  localparam logic [31:0] REG_FRAMES = 32'h14;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int CTRL_FRM_CLR = 3;

  localparam int STS_BUSY = 0;
  localparam int STS_DONE = 1;
  localparam int STS_ERR  = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_WAIT
  } state_t;

endpackage

// File: rtl/goertzel_axil_regs.sv
// AXI-lite slave and register file for goertzel_ctrl.
// GOERTZEL_CTRL_FRAMECNT_EN adds the FRAMES completed-block counter at 0x14.
module goertzel_axil_regs
  import goertzel_pkg::*;
#(
  parameter int COEFF_W = 18,
  parameter int RES_W   = 32,
  parameter int LEN_W   = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  axi_pkg::axi_lite_mosi axio_i,
  output axi_pkg::axi_lite_miso axii_o,
  input  logic                 busy,
  input  logic                 done_set,
  input  logic                 err_set,
  input  logic [RES_W-1:0]     result_in,
  output logic                 start,
  output logic                 abort,
  output logic                 irq_en,
  output logic                 irq,
  output logic [LEN_W-1:0]     len,
  output logic [COEFF_W-1:0]   coeff
);

  logic               aw_rdy, ar_rdy, bvalid, rvalid;
  logic [1:0]         bresp, rresp, rd_resp;
  logic [31:0]        rdata, rd_data, wdata;
  logic               wr_en, wr_ok, sel_ctrl, sel_sts;
  logic               done, err;
  logic [RES_W-1:0]   result;
  logic               unused;

  assign wdata    = axio_i.wdata;
  assign wr_en    = aw_rdy;
  assign sel_ctrl = wr_en && (axio_i.awaddr == REG_CTRL);
  assign sel_sts  = wr_en && (axio_i.awaddr == REG_STATUS);
  // ABORT dominates a simultaneous START in the same CTRL write
  assign start    = sel_ctrl && wdata[CTRL_START] && !wdata[CTRL_ABORT];
  assign abort    = sel_ctrl && wdata[CTRL_ABORT];
  assign irq      = irq_en && (done || err);
  assign unused   = ^wdata[31:COEFF_W];

  always_comb begin
    wr_ok = 1'b0;
    case (axio_i.awaddr)
      REG_CTRL, REG_STATUS, REG_LEN, REG_COEFF: wr_ok = 1'b1;
      default:                                  wr_ok = 1'b0;
    endcase
  end

`ifdef GOERTZEL_CTRL_FRAMECNT_EN
  logic [31:0] frames;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                               frames <= '0;
    else if (sel_ctrl && wdata[CTRL_FRM_CLR]) frames <= '0;
    else if (done_set)                       frames <= frames + 32'd1;
  end
`endif

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (axio_i.araddr)
      REG_CTRL:   rd_data[CTRL_IRQ_EN] = irq_en;
      REG_STATUS: begin
        rd_data[STS_BUSY] = busy;
        rd_data[STS_DONE] = done;
        rd_data[STS_ERR]  = err;
      end
      REG_LEN:    rd_data = 32'(len);
      REG_COEFF:  rd_data = 32'(coeff);
      REG_RESULT: rd_data = 32'(result);
`ifdef GOERTZEL_CTRL_FRAMECNT_EN
      REG_FRAMES: rd_data = frames;
`endif
      default:    rd_resp = RESP_DECERR;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_rdy <= 1'b0;
      bvalid <= 1'b0;
      bresp  <= RESP_OKAY;
      irq_en <= 1'b0;
      len    <= '0;
      coeff  <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      aw_rdy <= axio_i.awvalid && axio_i.wvalid && !aw_rdy && !bvalid;
      if (wr_en) begin
        bvalid <= 1'b1;
        bresp  <= wr_ok ? RESP_OKAY : RESP_DECERR;
      end else if (axio_i.bready) begin
        bvalid <= 1'b0;
      end
      if (sel_ctrl) irq_en <= wdata[CTRL_IRQ_EN];
      if (wr_en && axio_i.awaddr == REG_LEN)   len   <= wdata[LEN_W-1:0];
      if (wr_en && axio_i.awaddr == REG_COEFF) coeff <= wdata[COEFF_W-1:0];
      // a set strobe beats a same-cycle write-one-to-clear
      done <= done_set || (done && !(sel_sts && wdata[STS_DONE]));
      err  <= err_set  || (err  && !(sel_sts && wdata[STS_ERR]));
      if (done_set) result <= result_in;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ar_rdy <= 1'b0;
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else begin
      ar_rdy <= axio_i.arvalid && !ar_rdy && !rvalid;
      if (ar_rdy) begin
        rvalid <= 1'b1;
        rdata  <= rd_data;
        rresp  <= rd_resp;
      end else if (axio_i.rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    axii_o         = '0;
    axii_o.awready = aw_rdy;
    axii_o.wready  = aw_rdy;
    axii_o.bvalid  = bvalid;
    axii_o.bresp   = bresp;
    axii_o.arready = ar_rdy;
    axii_o.rvalid  = rvalid;
    axii_o.rdata   = rdata;
    axii_o.rresp   = rresp;
  end

endmodule

// File: rtl/goertzel_ctrl.sv
// Run sequencer for one Goertzel core: clear, gate LEN samples, capture result.
// Optional FRAMES counter is enabled with GOERTZEL_CTRL_FRAMECNT_EN.
//   state | meaning
//   IDLE  | waiting for START
//   CLEAR | one-cycle core state clear
//   RUN   | accepting samples into the core
//   WAIT  | last sample sent, waiting for core result
module goertzel_ctrl
  import goertzel_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int COEFF_W = 18,
  parameter int RES_W   = 32,
  parameter int LEN_W   = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  axi_pkg::axi_lite_mosi axio_i,
  output axi_pkg::axi_lite_miso axii_o,
  input  logic [DATA_W-1:0]     s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic                  core_clr,
  output logic                  core_en,
  output logic [DATA_W-1:0]     core_sample,
  output logic                  core_last,
  output logic [COEFF_W-1:0]    core_coeff,
  input  logic [RES_W-1:0]      core_res,
  input  logic                  core_res_vld,
  output logic                  irq
);

  state_t               state, state_nxt;
  logic                 start, abort, irq_en;
  logic [LEN_W-1:0]     len, len_snap, count;
  logic [COEFF_W-1:0]   coeff, coeff_snap;
  logic                 go, busy, done_set, err_set;

  assign busy       = (state != ST_IDLE);
  assign go         = (state == ST_IDLE) && start && (len != '0);
  assign err_set    = (state == ST_IDLE) && start && (len == '0);
  assign core_coeff = coeff_snap;

  goertzel_axil_regs #(
    .COEFF_W (COEFF_W),
    .RES_W   (RES_W),
    .LEN_W   (LEN_W)
  ) u_regs (
    .clk       (clk),
    .rstn      (rstn),
    .axio_i    (axio_i),
    .axii_o    (axii_o),
    .busy      (busy),
    .done_set  (done_set),
    .err_set   (err_set),
    .result_in (core_res),
    .start     (start),
    .abort     (abort),
    .irq_en    (irq_en),
    .irq       (irq),
    .len       (len),
    .coeff     (coeff)
  );

  always_comb begin
    state_nxt   = state;
    s_tready    = 1'b0;
    core_clr    = 1'b0;
    core_en     = 1'b0;
    core_sample = '0;
    core_last   = 1'b0;
    done_set    = 1'b0;
    case (state)
      ST_IDLE:  if (go) state_nxt = ST_CLEAR;
      ST_CLEAR: begin
        core_clr  = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        s_tready = 1'b1;
        if (s_tvalid) begin
          core_en     = 1'b1;
          core_sample = s_tdata;
          core_last   = (count == len_snap - LEN_W'(1));
          if (core_last) state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // a result landing in the ABORT cycle is discarded
        if (core_res_vld && !abort) begin
          done_set  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      len_snap   <= '0;
      coeff_snap <= '0;
      count      <= '0;
    end else begin
      state <= state_nxt;
      if (go) begin
        len_snap   <= len;
        coeff_snap <= coeff;
      end
      if (state == ST_CLEAR) count <= '0;
      else if (core_en)      count <= count + LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_goertzel_ctrl.sv
// Directed bench for goertzel_ctrl with a sample scoreboard checked on every core_en.
module tb_goertzel_ctrl;
  import axi_pkg::*;
  import goertzel_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  axi_lite_mosi axio;
  axi_lite_miso axii;
  logic [15:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready, core_clr, core_en, core_last;
  logic [15:0] core_sample;
  logic [17:0] core_coeff;
  logic [31:0] core_res = '0;
  logic        core_res_vld = 1'b0;
  logic        irq;

  always #5 clk = ~clk;

  goertzel_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .axio_i       (axio),
    .axii_o       (axii),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .core_clr     (core_clr),
    .core_en      (core_en),
    .core_sample  (core_sample),
    .core_last    (core_last),
    .core_coeff   (core_coeff),
    .core_res     (core_res),
    .core_res_vld (core_res_vld),
    .irq          (irq)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          en_cnt = 0;
  int          clr_cnt = 0;
  int          clr_cyc = 0;
  int          first_en_cyc = -1;
  int          we_cyc = 0;
  int          budget = 0;
  logic        last_seen = 1'b0;
  logic [17:0] exp_coeff = '0;
  logic        src_toggle = 1'b0;
  logic        src_phase = 1'b0;
  logic        take = 1'b0;
  logic        ien = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // sample source: increments data on each accepted sample, stops after budget
  always @(negedge clk) take = s_tvalid & s_tready;
  always @(posedge clk) begin
    #1;
    if (take) begin
      s_tdata = s_tdata + 16'd1;
      budget  = budget - 1;
    end
    src_phase = ~src_phase;
    s_tvalid  = (budget > 0) && (!src_toggle || src_phase);
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (core_clr) begin
        clr_cnt++;
        clr_cyc = cyc;
      end
      if (core_en) begin
        if (first_en_cyc < 0) first_en_cyc = cyc;
        en_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_sample", {31'b0, core_en}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sample", {16'b0, core_sample}, {16'b0, e.data});
          chk("last", {31'b0, core_last}, {31'b0, e.last});
        end
        chk("coeff", {14'b0, core_coeff}, {14'b0, exp_coeff});
        if (core_last) last_seen = 1'b1;
      end
    end
  end

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] resp);
    bit got;
    @(posedge clk); #1;
    axio.awaddr = a; axio.wdata = d;
    axio.awvalid = 1'b1; axio.wvalid = 1'b1; axio.bready = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = axii.awready; end
    if (!got) chk("aw_timeout", {31'b0, axii.awready}, 32'd1);
    @(posedge clk); #1;
    axio.awvalid = 1'b0; axio.wvalid = 1'b0;
    we_cyc = cyc;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = axii.bvalid; end
    if (!got) chk("b_timeout", {31'b0, axii.bvalid}, 32'd1);
    resp = axii.bresp;
    @(posedge clk); #1;
    axio.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit got;
    @(posedge clk); #1;
    axio.araddr = a; axio.arvalid = 1'b1; axio.rready = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = axii.arready; end
    if (!got) chk("ar_timeout", {31'b0, axii.arready}, 32'd1);
    @(posedge clk); #1;
    axio.arvalid = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = axii.rvalid; end
    if (!got) chk("r_timeout", {31'b0, axii.rvalid}, 32'd1);
    d = axii.rdata; resp = axii.rresp;
    @(posedge clk); #1;
    axio.rready = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] exp_resp);
    logic [1:0] r;
    axi_write(a, d, r);
    chk("bresp", {30'b0, r}, {30'b0, exp_resp});
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                    input logic [1:0] exp_resp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, d, r);
    chk(tag, d, exp_d);
    chk({tag, "_rresp"}, {30'b0, r}, {30'b0, exp_resp});
  endtask

  task automatic wait_last();
    for (int i = 0; i < 300 && !last_seen; i++) @(negedge clk);
    if (!last_seen) chk("last_timeout", {31'b0, last_seen}, 32'd1);
  endtask

  task automatic wait_en(input int target);
    for (int i = 0; i < 300 && en_cnt < target; i++) @(negedge clk);
    if (en_cnt < target) chk("sample_timeout", en_cnt, target);
  endtask

  task automatic pulse_result(input logic [31:0] v);
    @(posedge clk); #1;
    core_res = v; core_res_vld = 1'b1;
    @(posedge clk); #1;
    core_res_vld = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_samples(input int n, input logic [15:0] base, input bit with_last);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.data = base + 16'(i);
      e.last = with_last && (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  // full run with an always-valid source, including start-to-first-sample latency
  task automatic do_run(input int n, input logic [15:0] base, input logic [31:0] res);
    int c0, k0;
    src_toggle = 1'b0;
    s_tdata = base;
    budget = 1000;
    push_samples(n, base, 1'b1);
    last_seen = 1'b0;
    first_en_cyc = -1;
    c0 = en_cnt; k0 = clr_cnt;
    wr(REG_CTRL, {29'b0, ien, 2'b01}, RESP_OKAY);
    wait_last();
    chk("clr_cycle", clr_cyc, we_cyc);
    chk("first_sample_latency", first_en_cyc - we_cyc, 1);
    budget = 0;
    pulse_result(res);
    chk("run_sample_count", en_cnt - c0, n);
    chk("run_clr_count", clr_cnt - k0, 1);
  endtask

  initial begin
    int c0, k0;
    axio = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_tready", {31'b0, s_tready}, 32'd0);
    chk("rst_core_clr", {31'b0, core_clr}, 32'd0);
    chk("rst_core_en", {31'b0, core_en}, 32'd0);
    chk("rst_coeff", {14'b0, core_coeff}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    rd("rst_status", REG_STATUS, 32'd0, RESP_OKAY);
    rd("rst_len", REG_LEN, 32'd0, RESP_OKAY);
    rd("rst_result", REG_RESULT, 32'd0, RESP_OKAY);

    // basic 4-sample block
    wr(REG_LEN, 32'd4, RESP_OKAY);
    wr(REG_COEFF, 32'h1_2345, RESP_OKAY);
    exp_coeff = 18'h1_2345;
    do_run(4, 16'd1, 32'hDEAD_BEEF);
    rd("result1", REG_RESULT, 32'hDEAD_BEEF, RESP_OKAY);
    rd("status_done", REG_STATUS, 32'h2, RESP_OKAY);
    chk("irq_disabled", {31'b0, irq}, 32'd0);

    // interrupt on completion
    wr(REG_STATUS, 32'h2, RESP_OKAY);
    ien = 1'b1;
    wr(REG_CTRL, 32'h4, RESP_OKAY);
    chk("irq_before_run", {31'b0, irq}, 32'd0);
    do_run(4, 16'd11, 32'hCAFE_0001);
    chk("irq_on_done", {31'b0, irq}, 32'd1);
    rd("result2", REG_RESULT, 32'hCAFE_0001, RESP_OKAY);
    wr(REG_STATUS, 32'h2, RESP_OKAY);
    @(negedge clk);
    chk("irq_after_w1c", {31'b0, irq}, 32'd0);
    rd("status_cleared", REG_STATUS, 32'd0, RESP_OKAY);

    // START with zero length
    k0 = clr_cnt;
    wr(REG_LEN, 32'd0, RESP_OKAY);
    wr(REG_CTRL, 32'h5, RESP_OKAY);
    rd("status_err", REG_STATUS, 32'h4, RESP_OKAY);
    chk("len0_no_clr", clr_cnt - k0, 0);
    chk("len0_irq", {31'b0, irq}, 32'd1);
    wr(REG_STATUS, 32'h4, RESP_OKAY);
    rd("err_cleared", REG_STATUS, 32'd0, RESP_OKAY);

    // gapped source, START and LEN/COEFF writes during the run
    wr(REG_LEN, 32'd8, RESP_OKAY);
    src_toggle = 1'b1;
    s_tdata = 16'd21;
    budget = 1000;
    push_samples(8, 16'd21, 1'b1);
    last_seen = 1'b0;
    c0 = en_cnt; k0 = clr_cnt;
    wr(REG_CTRL, 32'h5, RESP_OKAY);
    rd("status_busy", REG_STATUS, 32'h1, RESP_OKAY);
    wr(REG_CTRL, 32'h5, RESP_OKAY);
    wr(REG_LEN, 32'd3, RESP_OKAY);
    wr(REG_COEFF, 32'h3_FFFF, RESP_OKAY);
    wait_last();
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("wait_tready", {31'b0, s_tready}, 32'd0);
    budget = 0;
    pulse_result(32'h1234_5678);
    chk("gapped_sample_count", en_cnt - c0, 8);
    chk("gapped_clr_count", clr_cnt - k0, 1);
    rd("status_no_err", REG_STATUS, 32'h2, RESP_OKAY);
    rd("len_updated", REG_LEN, 32'd3, RESP_OKAY);
    wr(REG_STATUS, 32'h2, RESP_OKAY);
    exp_coeff = 18'h3_FFFF;

    // ABORT after 3 of 8 samples
    wr(REG_LEN, 32'd8, RESP_OKAY);
    src_toggle = 1'b0;
    s_tdata = 16'd41;
    budget = 3;
    push_samples(3, 16'd41, 1'b0);
    c0 = en_cnt;
    wr(REG_CTRL, 32'h5, RESP_OKAY);
    wait_en(c0 + 3);
    wr(REG_CTRL, 32'h6, RESP_OKAY);
    @(negedge clk);
    chk("abort_tready", {31'b0, s_tready}, 32'd0);
    rd("abort_status", REG_STATUS, 32'd0, RESP_OKAY);
    pulse_result(32'h0000_0BAD);
    rd("abort_result", REG_RESULT, 32'h1234_5678, RESP_OKAY);
    rd("abort_status2", REG_STATUS, 32'd0, RESP_OKAY);
    chk("abort_queue_empty", exp_q.size(), 0);

    // START and ABORT together
    k0 = clr_cnt;
    wr(REG_CTRL, 32'h7, RESP_OKAY);
    rd("start_abort_status", REG_STATUS, 32'd0, RESP_OKAY);
    chk("start_abort_no_clr", clr_cnt - k0, 0);

    // reset during RUN
    s_tdata = 16'd51;
    budget = 3;
    push_samples(3, 16'd51, 1'b0);
    c0 = en_cnt;
    wr(REG_CTRL, 32'h1, RESP_OKAY);
    wait_en(c0 + 3);
    @(posedge clk); #1 rstn = 1'b0;
    @(negedge clk);
    chk("reset_tready", {31'b0, s_tready}, 32'd0);
    chk("reset_coeff", {14'b0, core_coeff}, 32'd0);
    @(posedge clk); #1 rstn = 1'b1;
    ien = 1'b0;
    exp_coeff = '0;
    rd("reset_status", REG_STATUS, 32'd0, RESP_OKAY);
    rd("reset_result", REG_RESULT, 32'd0, RESP_OKAY);
    rd("reset_len", REG_LEN, 32'd0, RESP_OKAY);
    chk("reset_queue_empty", exp_q.size(), 0);

    // unmapped and read-only accesses
    rd("unmapped_read", 32'h20, 32'd0, RESP_DECERR);
    wr(REG_RESULT, 32'h5555_AAAA, RESP_DECERR);
    wr(32'h20, 32'h1, RESP_DECERR);
    rd("result_ro", REG_RESULT, 32'd0, RESP_OKAY);

    // completed-block counter
    wr(REG_LEN, 32'd2, RESP_OKAY);
    do_run(2, 16'd61, 32'h0000_0061);
    do_run(2, 16'd71, 32'h0000_0071);
    do_run(2, 16'd81, 32'h0000_0081);
    rd("result_last", REG_RESULT, 32'h0000_0081, RESP_OKAY);
`ifdef GOERTZEL_CTRL_FRAMECNT_EN
    rd("frames_3", REG_FRAMES, 32'd3, RESP_OKAY);
    wr(REG_CTRL, 32'h8, RESP_OKAY);
    rd("frames_clr", REG_FRAMES, 32'd0, RESP_OKAY);
`else
    rd("frames_unmapped", REG_FRAMES, 32'd0, RESP_DECERR);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/goertzel_ctrl.md
Name: goertzel_ctrl

Overview:
- Sequencer and register front-end for one Goertzel core.
- CPU configures block length and coefficient over AXI-lite, then starts a run.
- Block clears the core, gates exactly LEN samples from an AXI-stream source into it, waits for the core result, latches it, and flags DONE / IRQ.
- Sits between the AXI-lite interconnect, the ADC sample stream and the Goertzel arithmetic core.

Parameters:
- DATA_W, 16, sample width.
- COEFF_W, 18, coefficient width (signed fixed-point, passed through unchanged).
- RES_W, 32, core result width (≤32, zero-extended on read).
- LEN_W, 16, block-length register width.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- axio_i  in  axi_lite_mosi  AXI-lite requests (axi_pkg).
- axii_o  out  axi_lite_miso  AXI-lite responses (axi_pkg).
- s_tdata  in  DATA_W  sample data.
- s_tvalid  in  1  sample valid.
- s_tready  out  1  sample ready.
- core_clr  out  1  one-cycle core state clear.
- core_en  out  1  sample strobe to core.
- core_sample  out  DATA_W  sample to core.
- core_last  out  1  marks final sample of block.
- core_coeff  out  COEFF_W  coefficient, static during run.
- core_res  in  RES_W  core result.
- core_res_vld  in  1  result valid pulse.
- irq  out  1  level interrupt.

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk.
- Reset values:
  - All outputs 0; FSM IDLE.
  - LEN=0, COEFF=0, RESULT=0, STATUS=0, IRQ_EN=0.
- Register map (32-bit, byte address):
  - 0x00 CTRL (W): bit0 START, self-clearing pulse; bit1 ABORT, pulse; bit2 IRQ_EN, sticky.
  - 0x04 STATUS: bit0 BUSY (RO); bit1 DONE (W1C); bit2 ERR (W1C).
  - 0x08 LEN (RW).
  - 0x0C COEFF (RW).
  - 0x10 RESULT (RO).
  - Unmapped addresses or writes to RO registers: resp 2'b11, write data dropped, rdata 0.
- AXI-lite write channel:
  - Wait until awvalid and wvalid are both high.
  - Assert awready and wready together for 1 cycle; register updates on that edge.
  - Then hold bvalid until bready.
- AXI-lite read channel:
  - On arvalid, assert arready for 1 cycle and latch araddr.
  - Next cycle: rvalid with data, held stable until rready.
  - Read and write channels are independent and may run concurrently.
- FSM states: IDLE, CLEAR, RUN, WAIT.
  - IDLE → CLEAR on START with LEN≠0. Coefficient and length snapshot taken here.
  - START with LEN=0 sets ERR and stays IDLE.
  - CLEAR: core_clr=1 for exactly 1 cycle → RUN. Sample counter reset to 0.
  - RUN: s_tready=1. Each s_tvalid&s_tready cycle:
    - core_en=1, core_sample=s_tdata, count++.
    - core_last=1 on handshake where count==LEN-1; then → WAIT.
  - WAIT: s_tready=0. On core_res_vld: RESULT←core_res, DONE←1 → IDLE.
- Latency: first sample accepted 2 cycles after START write edge.
- BUSY=1 in CLEAR, RUN and WAIT.
- START while BUSY: ignored, no ERR.
- LEN/COEFF writes while BUSY: register updates, active run uses its snapshot.
- ABORT in any state: → IDLE next cycle, no DONE, RESULT unchanged. core_res_vld arriving in that cycle is ignored.
- START and ABORT in the same write: ABORT wins.
- DONE set and W1C in same cycle: set wins.
- irq = IRQ_EN & (DONE | ERR).
- core_res_vld outside WAIT: ignored.
- Reset mid-run: immediate IDLE, all state cleared.

Optional Feature:
- Macro GOERTZEL_CTRL_FRAMECNT_EN.
- Defined:
  - 32-bit FRAMES register at 0x14 (RO), counts completed blocks (DONE events), wraps 0xFFFF_FFFF→0.
  - Writing 1 to CTRL bit3 clears it; clear wins over same-cycle increment.
- Undefined: 0x14 is unmapped (resp 2'b11), CTRL bit3 ignored.

Decomposition:
- goertzel_pkg: register offsets, CTRL/STATUS bit indices, FSM state enum, AXI resp constants (OKAY 2'b00, DECERR 2'b11).
- Reuse axi_pkg structs.
- One natural sub-module: goertzel_axil_regs (AXI-lite handshake and register file). It exports the START/ABORT pulses, LEN, COEFF and IRQ_EN; it takes the DONE/ERR set strobes and the RESULT value.

Test Plan:
- Write LEN=4, COEFF=0x1_2345, START; source always valid with samples 1,2,3,4:
  - core_clr 1 cycle, then 4 core_en pulses; core_last on sample 4; core_coeff=0x1_2345.
  - Core returns 0xDEAD_BEEF → RESULT reads 0xDEAD_BEEF, DONE=1.
- IRQ_EN=1, complete run → irq rises with DONE. W1C STATUS=0x2 → irq falls, BUSY=0.
- LEN=0, START → ERR=1, no core_clr, stays IDLE, BUSY=0.
- LEN=8, toggle s_tvalid every other cycle:
  - Exactly 8 core_en, no samples accepted in WAIT.
  - START mid-run ignored, LEN write mid-run does not change count.
- ABORT after 3 of 8 samples → IDLE next cycle, s_tready=0, DONE stays 0, RESULT unchanged. rstn pulse mid-RUN gives the same result.
- Read 0x20 → rresp=2'b11, rdata=0. With FRAMECNT_EN: 3 runs → 0x14 reads 3; clear via CTRL bit3 → 0.
